// File: rtl/ebi_pin_bank.sv
// ebi_pin_bank: decodes the 16-bit EBI bus into NUM_PINS square/PWM waveform channels.
// Define GLOBAL_CTRL_EN to add a run/restart control word at BASE_ADDR-1.
module ebi_pin_bank #(
  parameter int unsigned NUM_PINS  = 8,
  parameter int unsigned BASE_ADDR = 32'h32,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [15:0]         ebi_data,
  input  logic [20:0]         ebi_addr,
  input  logic                ebi_wr,
  input  logic                ebi_rd,
  input  logic                ebi_cs,
  output logic [NUM_PINS-1:0] pin_out
);

  localparam int unsigned PsW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [15:0] WaveSquare = 16'd1;
  localparam logic [15:0] WavePwm    = 16'd4;

  typedef enum logic [1:0] {StIdle, StPhase, StRun} ch_state_e;

  logic [1:0]     wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d, cs_sync_q, cs_sync_d;
  logic           wr_prev_q, wr_prev_d, wr_det;
  logic           cap_vld_q, cap_vld_d;
  logic [20:0]    cap_addr_q, cap_addr_d;
  logic [15:0]    cap_data_q, cap_data_d;
  logic [PsW-1:0] ps_q, ps_d;
  logic           tick, run, ctrl_restart, rd_act;
  logic           oe_q, oe_d;
  logic [15:0]    rdata_q, rdata_d, rd_val;
  logic [NUM_PINS-1:0] ch_we;
  logic [1:0]          wr_off;

  logic [NUM_PINS-1:0][15:0] wave_q, wave_d, freq_q, freq_d, phase_q, phase_d;
  logic [NUM_PINS-1:0][15:0] ticks_q, ticks_d, cur_q, cur_d, cnt_q, cnt_d;
  logic [NUM_PINS-1:0]       pin_q, pin_d;
  ch_state_e                 state_q [NUM_PINS];
  ch_state_e                 state_d [NUM_PINS];

  assign wr_det  = wr_prev_q & ~wr_sync_q[1] & ~cs_sync_q[1];
  assign rd_act  = ~rd_sync_q[1] & ~cs_sync_q[1];
  assign tick    = run && (ps_q == PsW'(PRESCALE - 1));
  assign pin_out = pin_q;
  assign ebi_data = oe_q ? rdata_q : 16'hzzzz;

`ifdef GLOBAL_CTRL_EN
  logic run_q, run_d, ctrl_we;
  always_comb begin
    ctrl_we      = cap_vld_q && ({11'b0, cap_addr_q} == BASE_ADDR - 1);
    run_d        = ctrl_we ? cap_data_q[0] : run_q;
    ctrl_restart = ctrl_we && cap_data_q[1];
  end
  always_ff @(posedge clk) begin
    if (reset) run_q <= 1'b0;
    else       run_q <= run_d;
  end
  assign run = run_q;
`else
  assign run          = 1'b1;
  assign ctrl_restart = 1'b0;
`endif

  // Bus front end: strobe synchronisers, write capture, prescaler, registered read mux.
  always_comb begin
    logic [31:0] base, waddr, raddr;
    wr_sync_d  = {wr_sync_q[0], ebi_wr};
    rd_sync_d  = {rd_sync_q[0], ebi_rd};
    cs_sync_d  = {cs_sync_q[0], ebi_cs};
    wr_prev_d  = wr_sync_q[1];
    cap_vld_d  = wr_det;
    cap_addr_d = wr_det ? ebi_addr : cap_addr_q;
    cap_data_d = wr_det ? ebi_data : cap_data_q;
    ps_d       = ps_q;
    if (run) ps_d = tick ? '0 : ps_q + 1'b1;

    waddr  = {11'b0, cap_addr_q};
    raddr  = {11'b0, ebi_addr};
    ch_we  = '0;
    wr_off = '0;
    rd_val = '0;
    for (int unsigned n = 0; n < NUM_PINS; n++) begin
      base = BASE_ADDR + 6 * n;
      if (cap_vld_q && waddr >= base && waddr < base + 4) begin
        ch_we[n] = 1'b1;
        wr_off   = 2'(waddr - base);
      end
      if (raddr >= base && raddr < base + 6) begin
        case (3'(raddr - base))
          3'd0:    rd_val = wave_q[n];
          3'd1:    rd_val = freq_q[n];
          3'd2:    rd_val = phase_q[n];
          3'd3:    rd_val = ticks_q[n];
          3'd4:    rd_val = cur_q[n];
          3'd5:    rd_val = {15'b0, pin_q[n]};
          default: rd_val = '0;
        endcase
      end
    end
`ifdef GLOBAL_CTRL_EN
    if (raddr == BASE_ADDR - 1) rd_val = {15'b0, run};
`endif
    oe_d    = rd_act;
    rdata_d = rd_act ? rd_val : rdata_q;
  end

  // Channel next state; a commit or global restart overrides any tick in the same cycle.
  always_comb begin
    logic [15:0] pwm_nxt;
    pwm_nxt = '0;
    wave_d  = wave_q;
    freq_d  = freq_q;
    phase_d = phase_q;
    ticks_d = ticks_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    state_d = state_q;
    for (int unsigned n = 0; n < NUM_PINS; n++) begin
      if (ch_we[n]) begin
        case (wr_off)
          2'd0:    wave_d[n]  = cap_data_q;
          2'd1:    freq_d[n]  = cap_data_q;
          2'd2:    phase_d[n] = cap_data_q;
          default: ticks_d[n] = cap_data_q;
        endcase
      end
      if (ch_we[n] || ctrl_restart) begin
        pin_d[n]   = 1'b0;
        cur_d[n]   = '0;
        cnt_d[n]   = phase_d[n];
        state_d[n] = (wave_d[n] == WaveSquare || wave_d[n] == WavePwm) ? StPhase : StIdle;
      end else if (tick) begin
        case (state_q[n])
          StPhase: begin
            if (cnt_q[n] == '0) begin
              state_d[n] = StRun;
              if (wave_q[n] == WavePwm) pin_d[n] = (freq_q[n] != '0) && (ticks_q[n] != '0);
              else                      pin_d[n] = (freq_q[n] != '0);
            end else begin
              cnt_d[n] = cnt_q[n] - 16'd1;
            end
          end
          StRun: begin
            cur_d[n] = cur_q[n] + 16'd1;
            if (freq_q[n] == '0) begin
              pin_d[n] = 1'b0;
              cnt_d[n] = '0;
            end else if (wave_q[n] == WavePwm) begin
              pwm_nxt  = (cnt_q[n] == freq_q[n] - 16'd1) ? '0 : cnt_q[n] + 16'd1;
              cnt_d[n] = pwm_nxt;
              pin_d[n] = pwm_nxt < ticks_q[n];
            end else if (cnt_q[n] == freq_q[n] - 16'd1) begin
              pin_d[n] = ~pin_q[n];
              cnt_d[n] = '0;
            end else begin
              cnt_d[n] = cnt_q[n] + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Strobes are active-low, so synchronisers reset to the idle (high) level.
      wr_sync_q  <= 2'b11;
      rd_sync_q  <= 2'b11;
      cs_sync_q  <= 2'b11;
      wr_prev_q  <= 1'b1;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      ps_q       <= '0;
      oe_q       <= 1'b0;
      rdata_q    <= '0;
      wave_q     <= '0;
      freq_q     <= '0;
      phase_q    <= '0;
      ticks_q    <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      pin_q      <= '0;
      state_q    <= '{default: StIdle};
    end else begin
      wr_sync_q  <= wr_sync_d;
      rd_sync_q  <= rd_sync_d;
      cs_sync_q  <= cs_sync_d;
      wr_prev_q  <= wr_prev_d;
      cap_vld_q  <= cap_vld_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      ps_q       <= ps_d;
      oe_q       <= oe_d;
      rdata_q    <= rdata_d;
      wave_q     <= wave_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      ticks_q    <= ticks_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      pin_q      <= pin_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_ebi_pin_bank.sv
// Directed bench for ebi_pin_bank: EBI register access, square/PWM waveforms, reset behaviour.
// Expected values are queued when stimulus is driven and popped when the DUT output is sampled.
module tb_ebi_pin_bank;

  localparam int unsigned NumPins = 8;
  localparam logic [15:0] BusIdle = 16'hFFFF;

  logic               clk = 1'b0;
  logic               reset;
  wire  [15:0]        ebi_data;
  logic [15:0]        tb_data;
  logic               tb_oe;
  logic [20:0]        ebi_addr;
  logic               ebi_wr, ebi_rd, ebi_cs;
  logic [NumPins-1:0] pin_out;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  assign ebi_data = tb_oe ? tb_data : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (ebi_data[i]);
  end

  ebi_pin_bank #(
    .NUM_PINS (NumPins),
    .BASE_ADDR(32'h32),
    .PRESCALE (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ebi_data(ebi_data),
    .ebi_addr(ebi_addr),
    .ebi_wr  (ebi_wr),
    .ebi_rd  (ebi_rd),
    .ebi_cs  (ebi_cs),
    .pin_out (pin_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [15:0] obs);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      chk(tag, obs, sb_q.pop_front());
    end
  endtask

  // Pin value after the k-th tick following a restart (k = 1 is the first tick).
  function automatic logic exp_pin(input int mode, input int freq, input int phase,
                                   input int ticks, input int k);
    int j;
    if (k <= phase || freq == 0) return 1'b0;
    j = k - phase - 1;
    if (mode == 1) return ((j / freq) % 2) == 0;
    return (j % freq) < ticks;
  endfunction

  task automatic push_pins(input int ch, input int mode, input int freq, input int phase,
                           input int ticks, input int n);
    for (int k = 1; k <= n; k++)
      sb_q.push_back(exp_pin(mode, freq, phase, ticks, k) ? (16'd1 << ch) : 16'd0);
  endtask

  task automatic pin_seq(input string tag, input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk_pop(tag, 16'(pin_out) & mask);
    end
  endtask

  // Returns one cycle after the commit edge, so the next posedge processes tick 1.
  task automatic wr_word(input logic [20:0] a, input logic [15:0] d);
    repeat (3) @(posedge clk);
    #1;
    ebi_addr = a;
    tb_data  = d;
    tb_oe    = 1'b1;
    ebi_cs   = 1'b0;
    ebi_wr   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ebi_wr = 1'b1;
    ebi_cs = 1'b1;
    tb_oe  = 1'b0;
  endtask

  task automatic rd_word(input string tag, input logic [20:0] a);
    ebi_addr = a;
    ebi_cs   = 1'b0;
    ebi_rd   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_early"}, ebi_data, BusIdle);
    @(posedge clk);
    #1;
    chk_pop(tag, ebi_data);
    ebi_rd = 1'b1;
    ebi_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_released"}, ebi_data, BusIdle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    ebi_wr   = 1'b1;
    ebi_rd   = 1'b1;
    ebi_cs   = 1'b1;
    ebi_addr = '0;
    tb_data  = '0;
    tb_oe    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    sb_q.push_back(16'h0000);
    chk_pop("rst_pins", 16'(pin_out));
    chk("rst_bus", ebi_data, BusIdle);
    for (int a = 'h32; a <= 'h37; a++) begin
      sb_q.push_back(16'h0000);
      rd_word("rst_reg", 21'(a));
    end
`ifdef GLOBAL_CTRL_EN
    wr_word(21'h31, 16'h0001);
`endif

    // ch0 square: freq 3, phase 2
    wr_word(21'h33, 16'd3);
    wr_word(21'h34, 16'd2);
    wr_word(21'h32, 16'd1);
    push_pins(0, 1, 3, 2, 0, 11);
    pin_seq("ch0_square", 16'h0001, 11);
    sb_q.push_back(16'd10);
    rd_word("ch0_cur_tick", 21'h36);

    // ch1 pwm: freq 4, phase 1, ticks 1 -> 4 -> 0
    wr_word(21'h39, 16'd4);
    wr_word(21'h3A, 16'd1);
    wr_word(21'h3B, 16'd1);
    wr_word(21'h38, 16'd4);
    push_pins(1, 4, 4, 1, 1, 12);
    pin_seq("ch1_pwm_t1", 16'h0002, 12);
    wr_word(21'h3B, 16'd4);
    push_pins(1, 4, 4, 1, 4, 8);
    pin_seq("ch1_pwm_t4", 16'h0002, 8);
    sb_q.push_back(16'h0001);
    rd_word("ch1_last_value", 21'h3D);
    wr_word(21'h3B, 16'd0);
    push_pins(1, 4, 4, 1, 0, 8);
    pin_seq("ch1_pwm_t0", 16'h0002, 8);

    // Read-only and unmapped writes are ignored
    wr_word(21'h32, 16'd0);
    wr_word(21'h36, 16'h1234);
    wr_word(21'h100, 16'h1234);
    sb_q.push_back(16'h0000);
    rd_word("ro_cur_tick", 21'h36);
    sb_q.push_back(16'h0000);
    rd_word("unmapped_rd", 21'h100);
    sb_q.push_back(16'd3);
    rd_word("ch0_freq_kept", 21'h33);
`ifndef GLOBAL_CTRL_EN
    sb_q.push_back(16'h0000);
    rd_word("ctrl_unmapped", 21'h31);
`endif

    // ch2 constant-high pwm, then reset with a read in flight
    wr_word(21'h3F, 16'd5);
    wr_word(21'h41, 16'd5);
    wr_word(21'h3E, 16'd4);
    push_pins(2, 4, 5, 0, 5, 4);
    pin_seq("ch2_pwm", 16'h0004, 4);
    ebi_addr = 21'h3F;
    ebi_cs   = 1'b0;
    ebi_rd   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_q.push_back(16'd5);
    chk_pop("rd_before_rst", ebi_data);
    sb_q.push_back(16'h0004);
    chk_pop("pin_before_rst", 16'(pin_out) & 16'h0004);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back(16'h0000);
    chk_pop("pins_after_rst", 16'(pin_out));
    chk("bus_after_rst", ebi_data, BusIdle);
    reset  = 1'b0;
    ebi_rd = 1'b1;
    ebi_cs = 1'b1;
    for (int a = 'h3E; a <= 'h43; a++) begin
      sb_q.push_back(16'h0000);
      rd_word("ch2_reg_after_rst", 21'(a));
    end
    sb_q.push_back(16'h0000);
    rd_word("ch0_freq_after_rst", 21'h33);

`ifdef GLOBAL_CTRL_EN
    // Configure with run=0, restart frozen, then restart with run=1
    wr_word(21'h33, 16'd2);
    wr_word(21'h34, 16'd1);
    wr_word(21'h32, 16'd1);
    wr_word(21'h39, 16'd2);
    wr_word(21'h3A, 16'd1);
    wr_word(21'h38, 16'd1);
    wr_word(21'h31, 16'h0002);
    for (int k = 0; k < 6; k++) sb_q.push_back(16'h0000);
    pin_seq("ctrl_frozen", 16'h0003, 6);
    sb_q.push_back(16'h0000);
    rd_word("ctrl_rd_stopped", 21'h31);
    wr_word(21'h31, 16'h0003);
    for (int k = 1; k <= 8; k++)
      sb_q.push_back(exp_pin(1, 2, 1, 0, k) ? 16'h0003 : 16'h0000);
    pin_seq("ctrl_aligned", 16'h0003, 8);
    sb_q.push_back(16'h0001);
    rd_word("ctrl_rd_run", 21'h31);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
